display_mux: RTL and testbench
==============================

Name: display_mux

Overview:
- Time-multiplexed N-digit 7-segment driver.
- Successor to the single-digit combinational decoder: it adds parametrised digit count, a registered scan engine with refresh prescaler, a load-strobed shadow register, optional hex glyphs, leading-zero blanking and selectable output polarity.
- Sits between the datapath (BCD/hex nibbles) and the board's shared segment bus plus per-digit enables.

Parameters:
- N_DIGITS, 4: number of digits scanned (1..8).
- REFRESH_DIV, 50000: clock cycles each digit is enabled (>=1).
- HEX_EN, 0: 1 = nibbles 10..15 show A b C d E F; 0 = nibbles 10..15 blank.
- ACTIVE_LOW, 0: 1 = segments, dp and an are inverted at the output registers.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- data  in  4*N_DIGITS  nibble i = data[4i+3:4i]; digit 0 is least significant.
- dp_in  in  N_DIGITS  decimal point per digit.
- load  in  1  capture data/dp_in into shadow registers.
- blank_lz  in  1  enable leading-zero blanking (sampled live, not shadowed).
- a, b, c, d, e, f, g  out  1 each  shared segment lines.
- dp  out  1  shared decimal point line.
- an  out  N_DIGITS  one-hot digit enable; an[i] selects digit i.

Behaviour:
- Reset (async, active-high) clears:
  - prescaler to 0 and digit index to 0;
  - shadow data and shadow dp to 0;
  - outputs to inactive: a..g and dp = 0, an = 0 (all 1 if ACTIVE_LOW).
- Shadow: on a clk edge with load=1, shadow <= data, dp_in. Without load, shadow holds. Outputs reflect the new shadow one edge later (load at edge k -> outputs change at edge k+1).
- Prescaler counts 0..REFRESH_DIV-1, width $clog2(REFRESH_DIV+1).
  - At terminal count it wraps to 0 and the index advances.
  - Index wraps N_DIGITS-1 -> 0.
  - With REFRESH_DIV=1 the index advances every cycle.
- Output registers update every cycle from the current index and shadow, so latency is 1 cycle from an index/shadow change. Exactly one bit of an is active outside reset.
- Glyph table, abcdefg, 1 = lit:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011
  - 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1110011
  - A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111 (HEX_EN=1 only)
  - 10..15 with HEX_EN=0 -> 0000000.
- Leading-zero blanking: when blank_lz=1, digit i (i>0) shows segments 0000000 if shadow nibbles i..N_DIGITS-1 are all zero. Digit 0 is never blanked. dp of a blanked digit is still driven from shadow dp.
- Polarity: ACTIVE_LOW inverts a..g, dp and an, including their reset values.
- Simultaneous load and index advance in the same cycle: both take effect; the next output uses the new index and the new shadow.
- Reset mid-scan: all state returns to its reset values immediately (asynchronous); the scan restarts at digit 0 with full REFRESH_DIV dwell.
- N_DIGITS=1: an is constant 1 outside reset; the index never changes.

Test Plan:
1. Reset, then release; N_DIGITS=4, REFRESH_DIV=3; shadow = 0 -> an cycles 0001,0010,0100,1000,0001, each for 3 clocks. Segments show 1111110 on digit 0 and on the other digits when blank_lz=0.
2. load=1 with data=16'h1234 and dp_in=4'b0100 -> from the next edge:
   - digit 0: 0110011 (4), digit 1: 1111001 (3), digit 2: 1101101 (2) with dp=1, digit 3: 0110000 (1).
   - Without a further load, later changes on data have no effect.
3. blank_lz=1, data=16'h0050 -> digits 3 and 2 show 0000000; digit 1 shows 1011011 (5); digit 0 shows 1111110 (0). Repeat with data=16'h0000 -> only digit 0 is lit (0).
4. data=16'hFA9C:
   - HEX_EN=1 -> digit 0 C=1001110, digit 1 9=1110011, digit 2 A=1110111, digit 3 F=1000111.
   - HEX_EN=0 -> digits 0, 2 and 3 show 0000000; digit 1 shows 9.
5. ACTIVE_LOW=1 -> during reset a..g, dp and an are all 1. Afterwards, digit 0 enabled gives an=1110, and the glyph for 8 gives segments 0000000.
6. Assert reset mid-dwell on digit 2 -> an immediately goes inactive. After release, an=0001 for the full 3 clocks. Also assert load on the same edge as an index advance -> the new digit shows the new data.

Source files
------------

// File: rtl/display_mux.sv
// -----------------------------------------------------------------------------
// display_mux
//
// Time-multiplexed N-digit 7-segment driver. A refresh prescaler paces a digit
// index through 0..N_DIGITS-1. Each digit stays enabled for REFRESH_DIV clocks.
// The nibble of the selected digit is taken from a load-strobed shadow register,
// decoded to a 7-segment glyph, and driven out through registered outputs.
//
// Parameters
//   N_DIGITS    number of scanned digits (1..8)
//   REFRESH_DIV clock cycles each digit stays enabled (>= 1)
//   HEX_EN      1: nibbles 10..15 render as A b C d E F; 0: they render blank
//   ACTIVE_LOW  1: a..g, dp and an are inverted at the output registers
//
// Ports
//   clk       in   system clock
//   reset     in   asynchronous, active-high reset
//   data      in   packed nibbles; nibble i = data[4i+3:4i], digit 0 is the LSD
//   dp_in     in   decimal point per digit
//   load      in   capture data/dp_in into the shadow registers
//   blank_lz  in   leading-zero blanking enable (used live, not shadowed)
//   a..g      out  shared segment lines
//   dp        out  shared decimal point line
//   an        out  one-hot digit enable, an[i] selects digit i
// -----------------------------------------------------------------------------
module display_mux #(
  parameter int N_DIGITS    = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int HEX_EN      = 0,
  parameter int ACTIVE_LOW  = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*N_DIGITS-1:0]   data,
  input  logic [N_DIGITS-1:0]     dp_in,
  input  logic                    load,
  input  logic                    blank_lz,
  output logic                    a,
  output logic                    b,
  output logic                    c,
  output logic                    d,
  output logic                    e,
  output logic                    f,
  output logic                    g,
  output logic                    dp,
  output logic [N_DIGITS-1:0]     an
);

  localparam int CNT_W = $clog2(REFRESH_DIV + 1);
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);
  // Output inversion mask bit; also the inactive level of every output.
  localparam logic POL = (ACTIVE_LOW != 0);

  // Glyph decode, abcdefg with 1 = lit (before polarity inversion).
  function automatic logic [6:0] f_glyph(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'b1111110;
      4'h1:    seg = 7'b0110000;
      4'h2:    seg = 7'b1101101;
      4'h3:    seg = 7'b1111001;
      4'h4:    seg = 7'b0110011;
      4'h5:    seg = 7'b1011011;
      4'h6:    seg = 7'b1011111;
      4'h7:    seg = 7'b1110000;
      4'h8:    seg = 7'b1111111;
      4'h9:    seg = 7'b1110011;
      4'hA:    seg = 7'b1110111;
      4'hB:    seg = 7'b0011111;
      4'hC:    seg = 7'b1001110;
      4'hD:    seg = 7'b0111101;
      4'hE:    seg = 7'b1001111;
      default: seg = 7'b1000111;
    endcase
    if (HEX_EN == 0 && nib > 4'd9) begin
      seg = 7'b0000000;
    end
    return seg;
  endfunction

  // Scan engine and shadow state
  logic [CNT_W-1:0] r_cnt;
  logic [IDX_W-1:0] r_idx;
  logic [3:0]       r_nib [N_DIGITS];
  logic [N_DIGITS-1:0] r_dp_sh;

  // Output stage registers
  logic [6:0]          r_seg_p1;
  logic                r_dp_p1;
  logic [N_DIGITS-1:0] r_an_p1;

  // Combinational selection of the current digit
  logic [N_DIGITS-1:0] w_upper_zero;
  logic [3:0]          w_nib;
  logic                w_dp_cur;
  logic                w_blank;
  logic [N_DIGITS-1:0] w_an_cur;
  logic [6:0]          w_seg;

  // ---- stage p0: prescaler and digit index ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_cnt <= '0;
      r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // ---- stage p0: shadow capture ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_DIGITS; i++) begin
        r_nib[i] <= 4'd0;
      end
      r_dp_sh <= '0;
    end else if (load) begin
      for (int i = 0; i < N_DIGITS; i++) begin
        r_nib[i] <= data[4*i +: 4];
      end
      r_dp_sh <= dp_in;
    end
  end

  // w_upper_zero[i] is set when shadow nibbles i..N_DIGITS-1 are all zero,
  // i.e. digit i is a leading zero.
  always_comb begin
    logic v_acc;
    v_acc        = 1'b1;
    w_upper_zero = '0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      v_acc           = v_acc & (r_nib[i] == 4'd0);
      w_upper_zero[i] = v_acc;
    end
  end

  // Select the nibble and dp of the current digit. A compare-per-digit mux
  // keeps the index from ever addressing a nonexistent digit.
  always_comb begin
    w_nib    = 4'd0;
    w_dp_cur = 1'b0;
    w_blank  = 1'b0;
    w_an_cur = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_nib       = r_nib[i];
        w_dp_cur    = r_dp_sh[i];
        // Digit 0 always shows its value, so a zero reading stays visible.
        w_blank     = blank_lz && (i != 0) && w_upper_zero[i];
        w_an_cur[i] = 1'b1;
      end
    end
    w_seg = w_blank ? 7'b0000000 : f_glyph(w_nib);
  end

  // ---- stage p1: registered outputs with polarity applied ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_seg_p1 <= {7{POL}};
      r_dp_p1  <= POL;
      r_an_p1  <= {N_DIGITS{POL}};
    end else begin
      r_seg_p1 <= w_seg ^ {7{POL}};
      r_dp_p1  <= w_dp_cur ^ POL;
      r_an_p1  <= w_an_cur ^ {N_DIGITS{POL}};
    end
  end

  assign {a, b, c, d, e, f, g} = r_seg_p1;
  assign dp = r_dp_p1;
  assign an = r_an_p1;

endmodule

// File: tb/tb_display_mux.sv
// Bench for display_mux: three instances share one stimulus stream
//   u_dec : N=4, DIV=3, decimal glyphs, active-high
//   u_hex : N=4, DIV=3, hex glyphs, active-low
//   u_one : N=1, DIV=1, hex glyphs, active-high
// A behavioural model predicts every output from the number of edges since
// reset release and the shadow contents, using plain arithmetic.
module tb_display_mux;

  logic        clk;
  logic        reset;
  logic [15:0] data;
  logic [3:0]  dp_in;
  logic        load;
  logic        blank_lz;

  logic [6:0] s0, s1, s2;
  logic       dp0, dp1, dp2;
  logic [3:0] an0, an1;
  logic [0:0] an2;

  int n_checks = 0;
  int n_fails  = 0;

  // Model state
  int          m_k;     // edges since reset release
  logic [15:0] m_sh;    // model shadow data
  logic [3:0]  m_dp;    // model shadow dp

  logic [6:0] gly [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                           7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                           7'b1111111, 7'b1110011, 7'b1110111, 7'b0011111,
                           7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

  display_mux #(.N_DIGITS(4), .REFRESH_DIV(3), .HEX_EN(0), .ACTIVE_LOW(0)) u_dec (
    .clk(clk), .reset(reset), .data(data), .dp_in(dp_in), .load(load),
    .blank_lz(blank_lz), .a(s0[6]), .b(s0[5]), .c(s0[4]), .d(s0[3]),
    .e(s0[2]), .f(s0[1]), .g(s0[0]), .dp(dp0), .an(an0));

  display_mux #(.N_DIGITS(4), .REFRESH_DIV(3), .HEX_EN(1), .ACTIVE_LOW(1)) u_hex (
    .clk(clk), .reset(reset), .data(data), .dp_in(dp_in), .load(load),
    .blank_lz(blank_lz), .a(s1[6]), .b(s1[5]), .c(s1[4]), .d(s1[3]),
    .e(s1[2]), .f(s1[1]), .g(s1[0]), .dp(dp1), .an(an1));

  display_mux #(.N_DIGITS(1), .REFRESH_DIV(1), .HEX_EN(1), .ACTIVE_LOW(0)) u_one (
    .clk(clk), .reset(reset), .data(data[3:0]), .dp_in(dp_in[0:0]), .load(load),
    .blank_lz(blank_lz), .a(s2[6]), .b(s2[5]), .c(s2[4]), .d(s2[3]),
    .e(s2[2]), .f(s2[1]), .g(s2[0]), .dp(dp2), .an(an2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {abcdefg, dp, an padded to 8 bits}.
  function automatic logic [15:0] model_out(input int n, input int div, input bit hex,
                                            input bit al, input int k, input logic [15:0] sh,
                                            input logic [3:0] dsh, input bit blz, input bit rst);
    logic [6:0] seg;
    logic       dpv;
    logic [7:0] anv;
    int         idx;
    logic [3:0] nib;
    seg = 7'd0;
    dpv = 1'b0;
    anv = 8'd0;
    if (!rst && k > 0) begin
      idx = ((k - 1) / div) % n;
      nib = sh[4*idx +: 4];
      seg = gly[nib];
      if (!hex && nib > 4'd9) seg = 7'd0;
      if (blz && idx > 0 && (sh >> (4*idx)) == 16'd0) seg = 7'd0;
      dpv = dsh[idx];
      anv = 8'd1 << idx;
    end
    if (al) begin
      seg = ~seg;
      dpv = ~dpv;
      anv = ~anv;
    end
    anv = anv & (8'hFF >> (8 - n));
    return {seg, dpv, anv};
  endfunction

  task automatic check_all(input string tag, input bit in_rst);
    logic [15:0] e0, e1, e2, o0, o1, o2;
    e0 = model_out(4, 3, 1'b0, 1'b0, m_k, m_sh, m_dp, blank_lz, in_rst);
    e1 = model_out(4, 3, 1'b1, 1'b1, m_k, m_sh, m_dp, blank_lz, in_rst);
    e2 = model_out(1, 1, 1'b1, 1'b0, m_k, {12'd0, m_sh[3:0]}, {3'd0, m_dp[0]}, blank_lz, in_rst);
    o0 = {s0, dp0, 4'd0, an0};
    o1 = {s1, dp1, 4'd0, an1};
    o2 = {s2, dp2, 7'd0, an2};
    n_checks++;
    assert (o0 === e0) else begin
      n_fails++;
      $error("FAIL %s dec k=%0d observed=%h expected=%h", tag, m_k, o0, e0);
    end
    n_checks++;
    assert (o1 === e1) else begin
      n_fails++;
      $error("FAIL %s hex_al k=%0d observed=%h expected=%h", tag, m_k, o1, e1);
    end
    n_checks++;
    assert (o2 === e2) else begin
      n_fails++;
      $error("FAIL %s one k=%0d observed=%h expected=%h", tag, m_k, o2, e2);
    end
  endtask

  // One clock edge: check outputs against the shadow as it stood before the
  // edge, then fold a load seen at that edge into the model.
  task automatic tick(input string tag);
    @(posedge clk);
    #1;
    m_k++;
    check_all(tag, 1'b0);
    if (load) begin
      m_sh = data;
      m_dp = dp_in;
    end
  endtask

  // Reset asserted mid-cycle, held across one edge, released mid-cycle.
  task automatic apply_reset(input string tag);
    #2 reset = 1'b1;
    #1 check_all({tag, "_async"}, 1'b1);
    @(posedge clk);
    #1 check_all({tag, "_hold"}, 1'b1);
    reset = 1'b0;
    m_k  = 0;
    m_sh = 16'd0;
    m_dp = 4'd0;
    #1 check_all({tag, "_rel"}, 1'b0);
  endtask

  initial begin
    logic [15:0] mask;
    reset    = 1'b1;
    data     = 16'd0;
    dp_in    = 4'd0;
    load     = 1'b0;
    blank_lz = 1'b0;
    m_k      = 0;
    m_sh     = 16'd0;
    m_dp     = 4'd0;

    repeat (2) @(posedge clk);
    #1 check_all("reset", 1'b1);
    reset = 1'b0;
    #1 check_all("release", 1'b0);

    // Zero shadow, full scan with no blanking
    repeat (14) tick("scan_zero");

    // Load 1234 with dp on digit 2; later data changes must not leak through
    data  = 16'h1234;
    dp_in = 4'b0100;
    load  = 1'b1;
    tick("load_1234");
    load = 1'b0;
    for (int i = 0; i < 14; i++) begin
      data  = 16'($urandom);
      dp_in = 4'($urandom);
      tick("hold_1234");
    end

    // Leading-zero blanking
    blank_lz = 1'b1;
    data = 16'h0050; dp_in = 4'b1000; load = 1'b1;
    tick("load_0050");
    load = 1'b0;
    repeat (13) tick("blank_0050");
    data = 16'h0000; dp_in = 4'b0000; load = 1'b1;
    tick("load_0000");
    load = 1'b0;
    repeat (13) tick("blank_0000");

    // Hex glyphs versus blanked 10..15
    blank_lz = 1'b0;
    data = 16'hFA9C; dp_in = 4'b0001; load = 1'b1;
    tick("load_FA9C");
    load = 1'b0;
    repeat (13) tick("hex_FA9C");

    // Reset in the middle of digit 2's dwell, then full dwell on digit 0
    apply_reset("rst_a");
    repeat (7) tick("to_digit2");
    apply_reset("rst_mid");
    repeat (3) tick("dwell0");

    // Load on the same edge as an index advance (edge 6 advances 1 -> 2)
    repeat (2) tick("pre_adv");
    data = 16'h8765; dp_in = 4'b0110; load = 1'b1;
    tick("load_adv");
    load = 1'b0;
    repeat (12) tick("post_adv");

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 3))
        0: mask = 16'hFFFF;
        1: mask = 16'h0FFF;
        2: mask = 16'h00FF;
        default: mask = 16'h000F;
      endcase
      data     = 16'($urandom) & mask;
      dp_in    = 4'($urandom);
      load     = ($urandom_range(0, 3) == 0);
      blank_lz = 1'($urandom);
      tick("random");
    end
    load = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
